// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU.
// Contents: opcode encodings, FSM states, divide-by-zero result constants.
package alu_pkg;

  localparam int unsigned ALU_WIDTH_DEF = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_MUL = 4'b1000,
    OP_DIV = 4'b1010,
    OP_REM = 4'b1011
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  // DIV by zero returns this bit replicated across the result (all ones).
  // REM by zero returns the dividend unchanged.
  localparam logic DIV0_QUO_FILL = 1'b1;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start_i               load operands and begin WIDTH iterations
//   dividend_i, divisor_i operands (divisor must be non-zero)
//   busy_o                iterations in progress
//   done_c_o              the iteration completing at the next edge is the last one
//   quotient_c_o          quotient after the current iteration
//   remainder_c_o         remainder after the current iteration
module alu_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_c_o,
  output logic [WIDTH-1:0] quotient_c_o,
  output logic [WIDTH-1:0] remainder_c_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic             busy_q;

  logic [WIDTH:0]   shift_c;
  logic [WIDTH:0]   diff_c;
  logic             fits_c;

  // One restoring step: shift in the next dividend bit, try subtracting.
  // quo_q doubles as the dividend shift register and the quotient collector.
  always_comb begin
    shift_c = {rem_q, quo_q[WIDTH-1]};
    diff_c  = shift_c - {1'b0, dsr_q};
    fits_c  = ~diff_c[WIDTH];
  end

  assign quotient_c_o  = {quo_q[WIDTH-2:0], fits_c};
  assign remainder_c_o = fits_c ? diff_c[WIDTH-1:0] : shift_c[WIDTH-1:0];
  assign done_c_o      = busy_q && (cnt_q == CNT_W'(1));
  assign busy_o        = busy_q;

  // Operand load and iteration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      cnt_q  <= CNT_W'(WIDTH);
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dsr_q  <= divisor_i;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= remainder_c_o;
      quo_q <= quotient_c_o;
      cnt_q <= cnt_q - CNT_W'(1);
      if (done_c_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake, registered results and
// an iterative divider for DIV/REM.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid, in_ready  request handshake (in_ready depends on state/out_ready only)
//   a, b, op            operands and opcode, captured on accept
//   out_valid, out_ready result handshake
//   result, zero, ovf   registered result, zero flag, signed overflow (ADD/SUB)
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);

  alu_state_e       state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;
  logic             rem_sel_q;

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] dif_c;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;
  logic             div_start_c;
  logic             accept_c;

  logic             div_busy;
  logic             div_done_c;
  logic [WIDTH-1:0] div_quo_c;
  logic [WIDTH-1:0] div_rem_c;
  logic [WIDTH-1:0] div_res_c;

  // A finished result can be replaced in the same cycle it is consumed.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept_c  = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

  // Single-cycle datapath; DIV/REM with non-zero divisor only flag a divider start.
  always_comb begin
    sum_c       = a + b;
    dif_c       = a - b;
    res_c       = '0;
    ovf_c       = 1'b0;
    div_start_c = 1'b0;
    case (op)
      OP_AND: res_c = a & b;
      OP_OR:  res_c = a | b;
      OP_ADD: begin
        res_c = sum_c;
        ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = dif_c;
        ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (dif_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: res_c = WIDTH'(a < b);
      OP_MUL: res_c = a * b;
      OP_DIV: begin
        if (b == '0) res_c = {WIDTH{DIV0_QUO_FILL}};
        else         div_start_c = 1'b1;
      end
      OP_REM: begin
        if (b == '0) res_c = a;
        else         div_start_c = 1'b1;
      end
      default: res_c = '0;
    endcase
  end

  alu_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (accept_c && div_start_c),
    .dividend_i   (a),
    .divisor_i    (b),
    .busy_o       (div_busy),
    .done_c_o     (div_done_c),
    .quotient_c_o (div_quo_c),
    .remainder_c_o(div_rem_c)
  );

  assign div_res_c = rem_sel_q ? div_rem_c : div_quo_c;

  // Control FSM and output registers; the divider's final step lands
  // directly in result_q so DONE follows the last iteration edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      zero_q    <= 1'b1;
      ovf_q     <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept_c) begin
            if (div_start_c) begin
              state_q   <= BUSY;
              rem_sel_q <= (op == OP_REM);
            end else begin
              state_q  <= DONE;
              result_q <= res_c;
              zero_q   <= (res_c == '0);
              ovf_q    <= ovf_c;
            end
          end else if ((state_q == DONE) && out_ready) begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          if (div_busy && div_done_c) begin
            state_q  <= DONE;
            result_q <= div_res_c;
            zero_q   <= (div_res_c == '0);
            ovf_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH = 32).
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = 4'b0000;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .ovf      (ovf)
  );

  task automatic drive(input logic v, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = v;
    op       = o;
    a        = x;
    b        = y;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, OP_AND, '0, '0);
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || zero !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got out_valid=%b result=%h zero=%b ovf=%b, want 0 00000000 1 0", out_valid, result, zero, ovf);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_add_sub();
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'h1);
    @(posedge clk); #1;
    drive(1'b0, OP_AND, '0, '0);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h8000_0000 || ovf !== 1'b1 || zero !== 1'b0) begin
      errors++;
      $display("FAIL add_ovf: got v=%b result=%h ovf=%b zero=%b, want 1 80000000 1 0", out_valid, result, ovf, zero);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_consume: got out_valid=%b, want 0", out_valid);
    end
    drive(1'b1, OP_SUB, 32'd5, 32'd5);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || result !== '0 || zero !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_zero: got v=%b result=%h zero=%b ovf=%b, want 1 00000000 1 0", out_valid, result, zero, ovf);
    end
    drive(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd2);
    @(posedge clk); #1;
    checks++;
    if (result !== 32'h1 || zero !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL add_carry: got result=%h zero=%b ovf=%b, want 00000001 0 0", result, zero, ovf);
    end
    drive(1'b1, OP_SUB, 32'h8000_0000, 32'h1);
    @(posedge clk); #1;
    checks++;
    if (result !== 32'h7FFF_FFFF || ovf !== 1'b1) begin
      errors++;
      $display("FAIL sub_ovf: got result=%h ovf=%b, want 7fffffff 1", result, ovf);
    end
    drive(1'b1, 4'b0011, 32'd5, 32'd3);
    @(posedge clk); #1;
    drive(1'b0, OP_AND, '0, '0);
    checks++;
    if (out_valid !== 1'b1 || result !== '0 || zero !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL undef_op: got v=%b result=%h zero=%b ovf=%b, want 1 00000000 1 0", out_valid, result, zero, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    int bad;
    out_ready = 1'b0;
    drive(1'b1, OP_DIV, 32'd100, 32'd7);
    @(posedge clk); #1;
    drive(1'b0, OP_DIV, 32'hFFFF, 32'h3);
    bad = (in_ready !== 1'b0 || out_valid !== 1'b0) ? 1 : 0;
    for (int c = 1; c < W; c++) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL div_busy_window: got %0d early/ready cycles, want 0", bad);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd14 || zero !== 1'b0) begin
      errors++;
      $display("FAIL div_result: got v=%b result=%0d zero=%b, want 1 14 0", out_valid, result, zero);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd14 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL div_hold: got v=%b result=%0d in_ready=%b, want 1 14 0", out_valid, result, in_ready);
    end
    out_ready = 1'b1;
    drive(1'b1, OP_REM, 32'd100, 32'd7);
    @(posedge clk); #1;
    drive(1'b0, OP_AND, '0, '0);
    out_ready = 1'b0;
    bad = 0;
    for (int c = 1; c < W; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    @(posedge clk); #1;
    checks++;
    if (bad !== 0 || out_valid !== 1'b1 || result !== 32'd2) begin
      errors++;
      $display("FAIL rem_result: got early=%0d v=%b result=%0d, want 0 1 2", bad, out_valid, result);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    out_ready = 1'b1;
    drive(1'b1, OP_DIV, 32'd9, 32'd0);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_by_zero: got v=%b result=%h, want 1 ffffffff", out_valid, result);
    end
    drive(1'b1, OP_REM, 32'd9, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, OP_AND, '0, '0);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd9) begin
      errors++;
      $display("FAIL rem_by_zero: got v=%b result=%0d, want 1 9", out_valid, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [3:0]   ops [6];
    logic [W-1:0] va  [6];
    logic [W-1:0] vb  [6];
    logic [W-1:0] exp [6];
    ops = '{OP_AND, OP_OR, OP_SLT, OP_SLT, OP_MUL, OP_MUL};
    va  = '{32'hF0F0_1234, 32'h1200_0034, 32'd3, 32'hFFFF_FFFF, 32'h0001_0000, 32'd7};
    vb  = '{32'h0FF0_FF00, 32'h0000_5600, 32'd5, 32'd1, 32'h0001_0003, 32'd6};
    exp = '{32'h00F0_1200, 32'h1200_5634, 32'd1, 32'd0, 32'h0003_0000, 32'd42};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, ops[i], va[i], vb[i]);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== exp[i]) begin
        errors++;
        $display("FAIL b2b_%0d: got v=%b rdy=%b result=%h, want 1 1 %h", i, out_valid, in_ready, result, exp[i]);
      end
    end
    drive(1'b1, OP_OR, 32'hA0, 32'h05);
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(1'b1, OP_AND, 32'hFF00, 32'h0FF0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'hA5) begin
        errors++;
        $display("FAIL stall_hold_%0d: got v=%b rdy=%b result=%h, want 1 0 000000a5", k, out_valid, in_ready, result);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, OP_AND, '0, '0);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'h0F00) begin
      errors++;
      $display("FAIL stall_release: got v=%b result=%h, want 1 00000f00", out_valid, result);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_div();
    int bad;
    out_ready = 1'b0;
    drive(1'b1, OP_DIV, 32'd1000, 32'd3);
    @(posedge clk); #1;
    drive(1'b0, OP_AND, '0, '0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || zero !== 1'b1 || ovf !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_div: got v=%b result=%h zero=%b ovf=%b rdy=%b, want 0 00000000 1 0 1", out_valid, result, zero, ovf, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < W + 4; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_abort: got %0d cycles with stale result or not ready, want 0", bad);
    end
    drive(1'b1, OP_DIV, 32'd50, 32'd5);
    @(posedge clk); #1;
    drive(1'b0, OP_AND, '0, '0);
    bad = 0;
    for (int c = 1; c < W; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    @(posedge clk); #1;
    checks++;
    if (bad !== 0 || out_valid !== 1'b1 || result !== 32'd10) begin
      errors++;
      $display("FAIL div_after_reset: got early=%0d v=%b result=%0d, want 0 1 10", bad, out_valid, result);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
